// File: rtl/dot_product_accumulator.sv
// Streaming LANES-wide dot-product engine: multiply, registered adder tree, accumulate until last beat.
// Build option: define DPA_SATURATE_EN to clamp the result to OUT_WIDTH instead of truncating.
module dot_product_accumulator #(
    parameter int DATA_WIDTH = 16,
    parameter int LANES      = 8,
    parameter int ACC_WIDTH  = 48,
    parameter int OUT_WIDTH  = 32,
    parameter int MAX_BEATS  = 256
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cfg_signed,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        in_last,
    input  logic [LANES*DATA_WIDTH-1:0] in_a,
    input  logic [LANES*DATA_WIDTH-1:0] in_b,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [OUT_WIDTH-1:0]        out_data,
    output logic                        out_err
);
    localparam int PROD_W = 2 * DATA_WIDTH;
    localparam int SUM_W  = PROD_W + $clog2(LANES);
    localparam int CNT_W  = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;

    typedef enum logic [1:0] {ST_ACCUM, ST_DRAIN, ST_HOLD} state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [CNT_W-1:0]       r_beat_cnt;
    logic                   r_signed;
    logic                   r_err;
    logic [PROD_W-1:0]      r_prod [LANES];
    logic                   r_s1_valid, r_s1_first, r_s1_last;
    logic [SUM_W-1:0]       r_sum;
    logic                   r_s2_valid, r_s2_first, r_s2_last;
    logic [ACC_WIDTH-1:0]   r_acc;
    logic                   r_s3_valid, r_s3_last;
    logic [OUT_WIDTH-1:0]   r_out_data;
    logic                   r_out_err;

    logic                   w_accept;
    logic                   w_first;
    logic                   w_signed_eff;
    logic                   w_force_last;
    logic                   w_last_eff;
    logic [PROD_W-1:0]      w_prod     [LANES];
    logic [SUM_W-1:0]       w_prod_ext [LANES];
    logic [SUM_W-1:0]       w_tree_sum;
    logic [ACC_WIDTH-1:0]   w_sum_ext;
    logic [OUT_WIDTH-1:0]   w_reduced;

    assign w_accept     = in_valid && in_ready;
    assign w_first      = (r_beat_cnt == '0);
    assign w_signed_eff = w_first ? cfg_signed : r_signed;
    assign w_force_last = (r_beat_cnt == CNT_W'(MAX_BEATS - 1));
    assign w_last_eff   = in_last || w_force_last;

    // Extending both operands to PROD_W makes the low PROD_W product bits correct for either signedness.
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            logic [DATA_WIDTH-1:0] w_a_lane, w_b_lane;
            logic [PROD_W-1:0]     w_a_ext, w_b_ext;
            assign w_a_lane       = in_a[gi*DATA_WIDTH +: DATA_WIDTH];
            assign w_b_lane       = in_b[gi*DATA_WIDTH +: DATA_WIDTH];
            assign w_a_ext        = {{DATA_WIDTH{w_signed_eff & w_a_lane[DATA_WIDTH-1]}}, w_a_lane};
            assign w_b_ext        = {{DATA_WIDTH{w_signed_eff & w_b_lane[DATA_WIDTH-1]}}, w_b_lane};
            assign w_prod[gi]     = w_a_ext * w_b_ext;
            assign w_prod_ext[gi] = {{(SUM_W-PROD_W){r_signed & r_prod[gi][PROD_W-1]}}, r_prod[gi]};
        end
    endgenerate

    always_comb begin
        w_tree_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            w_tree_sum = w_tree_sum + w_prod_ext[i];
        end
    end

    always_comb begin
        w_sum_ext = {ACC_WIDTH{r_signed & r_sum[SUM_W-1]}};
        w_sum_ext[SUM_W-1:0] = r_sum;
    end

`ifdef DPA_SATURATE_EN
    logic [ACC_WIDTH-1:0] w_sh_s;
    logic [ACC_WIDTH-1:0] w_sh_u;
    always_comb begin
        w_sh_s    = $signed(r_acc) >>> (OUT_WIDTH - 1);
        w_sh_u    = r_acc >> OUT_WIDTH;
        w_reduced = r_acc[OUT_WIDTH-1:0];
        if (r_signed) begin
            if (w_sh_s != '0 && w_sh_s != '1) begin
                w_reduced = r_acc[ACC_WIDTH-1] ? {1'b1, {(OUT_WIDTH-1){1'b0}}}
                                               : {1'b0, {(OUT_WIDTH-1){1'b1}}};
            end
        end else if (w_sh_u != '0) begin
            w_reduced = '1;
        end
    end
`else
    assign w_reduced = r_acc[OUT_WIDTH-1:0];
`endif

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_ACCUM: if (w_accept && w_last_eff) w_state_next = ST_DRAIN;
            ST_DRAIN: if (r_s3_valid && r_s3_last) w_state_next = ST_HOLD;
            ST_HOLD:  if (out_ready) w_state_next = ST_ACCUM;
            default:  w_state_next = ST_ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= ST_ACCUM;
            r_beat_cnt <= '0;
            r_signed   <= 1'b0;
            r_err      <= 1'b0;
            r_s1_valid <= 1'b0;
            r_s1_first <= 1'b0;
            r_s1_last  <= 1'b0;
            r_sum      <= '0;
            r_s2_valid <= 1'b0;
            r_s2_first <= 1'b0;
            r_s2_last  <= 1'b0;
            r_acc      <= '0;
            r_s3_valid <= 1'b0;
            r_s3_last  <= 1'b0;
            r_out_data <= '0;
            r_out_err  <= 1'b0;
            for (int i = 0; i < LANES; i++) r_prod[i] <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_beat_cnt <= r_beat_cnt + CNT_W'(1);
                if (w_first) r_signed <= cfg_signed;
                if (w_force_last && !in_last) r_err <= 1'b1;
            end else if (r_state == ST_HOLD && out_ready) begin
                r_beat_cnt <= '0;
                r_err      <= 1'b0;
            end

            r_s1_valid <= w_accept;
            r_s1_first <= w_accept && w_first;
            r_s1_last  <= w_accept && w_last_eff;
            if (w_accept) begin
                for (int i = 0; i < LANES; i++) r_prod[i] <= w_prod[i];
            end

            r_s2_valid <= r_s1_valid;
            r_s2_first <= r_s1_first;
            r_s2_last  <= r_s1_last;
            if (r_s1_valid) r_sum <= w_tree_sum;

            // First beat of a vector overwrites rather than adds, dropping the previous result.
            r_s3_valid <= r_s2_valid;
            r_s3_last  <= r_s2_valid && r_s2_last;
            if (r_s2_valid) r_acc <= r_s2_first ? w_sum_ext : r_acc + w_sum_ext;

            if (r_state == ST_DRAIN && w_state_next == ST_HOLD) begin
                r_out_data <= w_reduced;
                r_out_err  <= r_err;
            end
        end
    end

    assign in_ready  = rst && (r_state == ST_ACCUM);
    assign out_valid = (r_state == ST_HOLD);
    assign out_data  = r_out_data;
    assign out_err   = r_out_err;

endmodule

// File: tb/tb_dot_product_accumulator.sv
// Scoreboard bench for dot_product_accumulator: directed vectors, expected results queued, monitor pops on handshake.
`timescale 1ns/1ps
module tb_dot_product_accumulator;
    localparam int DW = 16;
    localparam int L  = 8;
    localparam int OW = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            cfg_signed = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_last = 1'b0;
    logic            out_ready = 1'b1;
    logic [L*DW-1:0] in_a = '0;
    logic [L*DW-1:0] in_b = '0;
    logic            in_ready;
    logic            out_valid;
    logic [OW-1:0]   out_data;
    logic            out_err;

    logic [OW:0]     exp_q[$];
    int              n_vec  = 0;
    int              n_miss = 0;

    always #5 clk = ~clk;

    dot_product_accumulator #(
        .DATA_WIDTH(DW), .LANES(L), .ACC_WIDTH(48), .OUT_WIDTH(OW), .MAX_BEATS(256)
    ) dut (
        .clk(clk), .rst(rst), .cfg_signed(cfg_signed),
        .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_err(out_err)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    // Monitor: sampled 1ns after the falling edge so same-edge stimulus changes are visible.
    logic          prev_hold = 1'b0;
    logic [OW:0]   prev_res  = '0;
    always begin
        @(negedge clk);
        #1;
        if (rst && out_valid) begin
            if (prev_hold) check("hold_stable", {out_err, out_data}, prev_res);
            if (out_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_miss++;
                    $display("FAIL spurious_valid: got result %0h expected none", {out_err, out_data});
                end else begin
                    check("result", {out_err, out_data}, exp_q.pop_front());
                end
            end
        end
        prev_hold = rst && out_valid && !out_ready;
        prev_res  = {out_err, out_data};
    end

    task automatic send_beat(input logic [DW-1:0] a, input logic [DW-1:0] b,
                             input logic last, input logic sgn);
        int cyc = 0;
        in_valid   = 1'b1;
        in_a       = {L{a}};
        in_b       = {L{b}};
        in_last    = last;
        cfg_signed = sgn;
        while (!in_ready && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        if (!in_ready) begin
            n_vec++;
            n_miss++;
            $display("FAIL accept_timeout: got in_ready=0 expected 1 within 50 cycles");
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_valid();
        int cyc = 0;
        while (!out_valid && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        if (!out_valid) begin
            n_vec++;
            n_miss++;
            $display("FAIL valid_timeout: got out_valid=0 expected 1 within 50 cycles");
        end
    endtask

    initial begin
        logic [OW-1:0] exp_big;
        int cyc;
`ifdef DPA_SATURATE_EN
        exp_big = 32'h7FFF_FFFF;
`else
        exp_big = 32'hFFF8_0008;
`endif
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_in_ready",  64'(in_ready),  64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data",  64'(out_data),  64'd0);
        check("rst_out_err",   64'(out_err),   64'd0);
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", 64'(in_ready), 64'd1);

        // Unsigned 4 beats of 1*2 per lane: 8*2*4 = 64, valid exactly 3 edges after the last handshake.
        exp_q.push_back({1'b0, 32'd64});
        for (int i = 0; i < 4; i++) send_beat(16'd1, 16'd2, (i == 3), 1'b0);
        for (int k = 0; k < 3; k++) begin
            check("latency_not_yet", 64'(out_valid), 64'd0);
            @(negedge clk);
        end
        check("latency_valid", 64'(out_valid), 64'd1);
        @(negedge clk);

        // Signed -3*5*8 = -120.
        exp_q.push_back({1'b0, 32'hFFFF_FF88});
        send_beat(16'hFFFD, 16'd5, 1'b1, 1'b1);
        wait_valid();
        @(negedge clk);

        // Signed 0x7FFF^2*8 = 0x1FFF80008: clamps or truncates depending on build.
        exp_q.push_back({1'b0, exp_big});
        send_beat(16'h7FFF, 16'h7FFF, 1'b1, 1'b1);
        wait_valid();
        @(negedge clk);

        // Signedness latched on beat 1; cfg_signed dropping on beat 2 must be ignored: -8 + -8 = -16.
        exp_q.push_back({1'b0, 32'hFFFF_FFF0});
        send_beat(16'hFFFF, 16'd1, 1'b0, 1'b1);
        send_beat(16'hFFFF, 16'd1, 1'b1, 1'b0);
        wait_valid();
        @(negedge clk);

        // Backpressure: 3*4*8 = 96 held for 5 cycles, then back-to-back 5*6*8*2 = 480.
        out_ready = 1'b0;
        exp_q.push_back({1'b0, 32'd96});
        send_beat(16'd3, 16'd4, 1'b1, 1'b0);
        wait_valid();
        for (int k = 0; k < 5; k++) begin
            check("stall_in_ready",  64'(in_ready),  64'd0);
            check("stall_out_valid", 64'(out_valid), 64'd1);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("release_in_ready",  64'(in_ready),  64'd1);
        check("release_out_valid", 64'(out_valid), 64'd0);
        exp_q.push_back({1'b0, 32'd480});
        send_beat(16'd5, 16'd6, 1'b0, 1'b0);
        send_beat(16'd5, 16'd6, 1'b1, 1'b0);
        wait_valid();
        @(negedge clk);

        // 256 beats with no in_last: forced termination, 256*8 = 2048 with error flag.
        exp_q.push_back({1'b1, 32'd2048});
        for (int i = 0; i < 256; i++) send_beat(16'd1, 16'd1, 1'b0, 1'b0);
        check("force_in_ready", 64'(in_ready), 64'd0);
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            if (in_ready) check("force_in_ready", 64'(in_ready), 64'd0);
            @(negedge clk);
            cyc++;
        end
        check("force_out_valid", 64'(out_valid), 64'd1);
        @(negedge clk);

        // Reset after 2 beats of a 4-beat vector, then a fresh 1-beat vector of ones: 8.
        send_beat(16'd9, 16'd9, 1'b0, 1'b0);
        send_beat(16'd9, 16'd9, 1'b0, 1'b0);
        rst = 1'b0;
        #1;
        check("midrst_in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_out_data",  64'(out_data),  64'd0);
        check("midrst_out_err",   64'(out_err),   64'd0);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_recover_ready", 64'(in_ready), 64'd1);
        exp_q.push_back({1'b0, 32'd8});
        send_beat(16'd1, 16'd1, 1'b1, 1'b0);
        wait_valid();
        repeat (3) @(negedge clk);

        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/dot_product_accumulator.md
# dot_product_accumulator

Streaming, pipelined inner-product engine. Each accepted beat carries LANES operand pairs. The block multiplies lane-wise, reduces the products through a registered adder tree, and accumulates across beats until `in_last`. It then presents one result through a valid/ready output handshake. It generalises the single-shot, fixed-length inner-product unit to arbitrary vector lengths, selectable signedness, backpressure and overflow handling. It sits between the operand-fetch stage and the result writeback in the GEMM datapath.

## Interface
- `DATA_WIDTH`, 16, operand width per lane
- `LANES`, 8, operand pairs per beat; power of two, ≥2
- `ACC_WIDTH`, 48, accumulator width; must be ≥ 2*DATA_WIDTH+$clog2(LANES)
- `OUT_WIDTH`, 32, result width; must be ≤ ACC_WIDTH
- `MAX_BEATS`, 256, maximum beats per vector before forced termination
- `clk` in 1: single clock, rising edge
- `rst` in 1: synchronous, active-low reset
- `cfg_signed` in 1: 1 means two's-complement operands, 0 means unsigned; sampled on the first beat of each vector
- `in_valid` in 1: input beat valid
- `in_ready` out 1: block can accept a beat
- `in_last` in 1: beat is the final beat of the vector
- `in_a` in LANES*DATA_WIDTH: operand A; lane i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- `in_b` in LANES*DATA_WIDTH: operand B, same packing as `in_a`
- `out_valid` out 1: result valid
- `out_ready` in 1: consumer accepts the result
- `out_data` out OUT_WIDTH: dot-product result
- `out_err` out 1: vector was force-terminated at MAX_BEATS

## Operation
- A beat is accepted when `in_valid && in_ready` at a rising edge.
- Pipeline stages:
  - S1 registers the LANES products, each 2*DATA_WIDTH wide, sign- or zero-extended per the latched signedness.
  - S2 registers the adder-tree sum, 2*DATA_WIDTH+$clog2(LANES) wide.
  - S3 adds the sum into the accumulator (ACC_WIDTH), which wraps modulo 2^ACC_WIDTH.
- The accumulator clears on the S3 update of each vector's first beat, so there is no leftover from the previous vector.
- The signedness latch captures `cfg_signed` on the first beat; changes to `cfg_signed` mid-vector are ignored.
- Beat counter runs 0..MAX_BEATS-1. An accepted beat with the counter at MAX_BEATS-1 is treated as last even if `in_last`=0, and sets the error flag for that vector.
- FSM:
  - ACCUM (`in_ready`=1): on an accepted last beat, go to DRAIN.
  - DRAIN (`in_ready`=0): wait until that beat leaves S3, then go to HOLD.
  - HOLD (`out_valid`=1, `in_ready`=0): on `out_ready`=1, go to ACCUM and clear the counter and error flag.
- `out_data` is the accumulator reduced to OUT_WIDTH (see Configuration) and is held stable throughout HOLD. `out_err` is valid alongside `out_valid`.
- A single-beat vector (`in_last` on the first beat) is legal.
- All-zero operands give `out_data`=0.

## Timing
- Reset (`rst`=0 at an edge): state ACCUM; `in_ready`=0 while `rst` is low; `out_valid`=0, `out_data`=0, `out_err`=0. Pipeline valids, accumulator and counter are cleared.
- `in_ready`=1 on the first cycle after `rst` deasserts.
- Throughput: one beat per cycle within a vector.
- Latency: last beat accepted at edge t → `out_valid`=1 from edge t+3.
- Result accepted at edge h → `in_ready`=1 from edge h (registered state). The next vector's first beat may be accepted at edge h+1.
- Reset mid-vector or during HOLD discards all in-flight state. No partial result is ever emitted.
- `out_valid` never deasserts without `out_ready`. `out_data` and `out_err` do not change while `out_valid`=1 and `out_ready`=0.

## Configuration
- `DPA_SATURATE_EN` defined: the accumulator clamps to the OUT_WIDTH range when reduced to `out_data`.
  - Signed mode: [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
  - Unsigned mode: [0, 2^OUT_WIDTH-1].
- `DPA_SATURATE_EN` undefined: `out_data` = accumulator[OUT_WIDTH-1:0], plain truncation.
- Accumulator wrap at ACC_WIDTH is unaffected by the macro.

## Test plan
- Unsigned, all lanes a=1, b=2, 4 beats with `in_last` on beat 4 → `out_data`=64, `out_err`=0, `out_valid` 3 cycles after the last handshake.
- Signed, a=0xFFFD (-3), b=5 on all lanes, single beat → `out_data`=0xFFFFFF88 (-120).
- Signed, a=b=0x7FFF on all lanes, 1 beat (sum 0x1FFF80008) → `out_data`=0x7FFFFFFF with `DPA_SATURATE_EN`, 0xFFF80008 without.
- `out_ready` held 0 for 5 cycles after `out_valid` → `out_data` stable, `in_ready`=0 throughout. Release → `in_ready`=1 at the same edge, then back-to-back vector accepted.
- 256 beats of a=1, b=1, unsigned, `in_last` never asserted → after beat 256 `out_data`=2048, `out_err`=1, `in_ready`=0 until the handshake.
- `rst` pulsed low for 1 cycle after beat 2 of a 4-beat vector, then a fresh 1-beat vector a=b=1 → `out_data`=8; no stale contribution and no spurious `out_valid`.
